// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache refill arbiter.
package cache_mem_pkg;

  localparam int          WORDS_PER_BLK = 8;
  localparam logic [15:0] BLK_MASK      = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_fill_counter.sv
// Block refill bookkeeping: issue/receive word counters, word address generation, last-word detect.
module mem_fill_counter
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              issue_en_i,
  input  logic              recv_vld_i,
  output logic              issue_vld_o,
  output logic [ADDR_W-1:0] issue_addr_o,
  output logic              recv_take_o,
  output logic [2:0]        recv_word_o,
  output logic              last_word_o
);

  localparam logic [3:0] CNT_MAX = 4'(WORDS_PER_BLK);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        issue_cnt_q, issue_cnt_d;
  logic [3:0]        recv_cnt_q, recv_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  // issue_cnt stops at CNT_MAX so a long memory latency never re-issues words
  assign issue_vld_o  = issue_cnt_q < CNT_MAX;
  assign issue_addr_o = base_q | ADDR_W'({issue_cnt_q[2:0], 1'b0});
  assign recv_take_o  = recv_vld_i && (recv_cnt_q < CNT_MAX);
  assign recv_word_o  = recv_cnt_q[2:0];
  assign last_word_o  = recv_cnt_q == (CNT_MAX - 4'd1);

  always_comb begin
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    recv_cnt_d  = recv_cnt_q;
    if (load_i) begin
      base_d      = base_i;
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
    end else begin
      if (issue_en_i && issue_vld_o) issue_cnt_d = issue_cnt_q + 4'd1;
      if (recv_take_o)               recv_cnt_d  = recv_cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the single memory port between write-through stores, D-misses and I-misses (fixed priority)
// and sequences 8-word block refills, steering returning data into the owning cache.
module cache_fill_arbiter
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_valid,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic [2:0]        fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              d_wr_ack,
  output logic              i_busy,
  output logic              d_busy
);

  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(BLK_MASK);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              cnt_load;
  logic [ADDR_W-1:0] base_sel;
  logic              issue_vld;
  logic [ADDR_W-1:0] issue_addr;
  logic              recv_take;
  logic [2:0]        recv_word;
  logic              last_word;

  mem_fill_counter #(
    .ADDR_W(ADDR_W)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .load_i       (cnt_load),
    .base_i       (base_sel),
    .issue_en_i   (state_q == FILL),
    .recv_vld_i   ((state_q == FILL) && mem_data_valid),
    .issue_vld_o  (issue_vld),
    .issue_addr_o (issue_addr),
    .recv_take_o  (recv_take),
    .recv_word_o  (recv_word),
    .last_word_o  (last_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign fill_data = mem_data_in;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cnt_load    = 1'b0;
    base_sel    = i_miss_addr & MASK;
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    fill_word   = '0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    i_busy      = 1'b0;
    d_busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_wr_req) begin
          state_d   = WRITE;
          wr_addr_d = d_wr_addr;
          wr_data_d = d_wr_data;
        end else if (d_miss) begin
          state_d  = FILL;
          owner_d  = OWN_D;
          cnt_load = 1'b1;
          base_sel = d_miss_addr & MASK;
        end else if (i_miss) begin
          state_d  = FILL;
          owner_d  = OWN_I;
          cnt_load = 1'b1;
        end
      end

      WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = wr_addr_q;
        mem_wdata  = wr_data_q;
        d_wr_ack   = 1'b1;
        d_busy     = 1'b1;
        state_d    = IDLE;
      end

      FILL: begin
        i_busy = (owner_q == OWN_I);
        d_busy = (owner_q == OWN_D);
        if (issue_vld) begin
          mem_enable = 1'b1;
          mem_addr   = issue_addr;
        end
        // the final word's write and the done pulse share a cycle so the cache can set tag/valid at once
        if (recv_take) begin
          i_fill_we = (owner_q == OWN_I);
          d_fill_we = (owner_q == OWN_D);
          fill_word = recv_word;
          if (last_word) begin
            i_fill_done = (owner_q == OWN_I);
            d_fill_done = (owner_q == OWN_D);
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
